// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiters.
//   NumHosts  - number of hosts merged onto one RAM port
//   StreakW   - width of the consecutive-grant counter
//   host_id_t - host index (0 = core LSU, 1 = debug/DMA)
//   mem_req_t - one forwarded RAM request
//   streak_bump() - saturating increment of the streak counter
package ram_arb_pkg;

  localparam int unsigned NumHosts = 2;
  localparam int unsigned StreakW  = 4;

  typedef logic [0:0]         host_id_t;
  typedef logic [StreakW-1:0] streak_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic streak_t streak_bump(input streak_t cur, input streak_t cap);
    return (cur >= cap) ? cap : cur + streak_t'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: host-side req/gnt/rvalid buses for two hosts plus the
// single downstream RAM port. Signal names keep the arbiter-relative _i/_o
// suffixes of the original flat port list.
//   modport slave  - the arbiter
//   modport master - the hosts and the RAM surrounding the arbiter
interface ram_port_arbiter_if;
  import ram_arb_pkg::*;

  logic [NumHosts-1:0]       h_req_i;
  logic [NumHosts-1:0]       h_we_i;
  logic [NumHosts-1:0][3:0]  h_be_i;
  logic [NumHosts-1:0][31:0] h_addr_i;
  logic [NumHosts-1:0][31:0] h_wdata_i;
  logic [NumHosts-1:0]       h_gnt_o;
  logic [NumHosts-1:0]       h_rvalid_o;
  logic [NumHosts-1:0][31:0] h_rdata_o;
  logic [NumHosts-1:0]       h_err_o;

  logic                      ram_req_o;
  logic                      ram_we_o;
  logic [3:0]                ram_be_o;
  logic [31:0]               ram_addr_o;
  logic [31:0]               ram_wdata_o;
  logic [31:0]               ram_rdata_i;
  logic                      ram_rvalid_i;

  modport slave (
    input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
    output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i, ram_rvalid_i
  );

  modport master (
    output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
    input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i, ram_rvalid_i
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin winner select.
//   req_i        - request per host
//   rr_ptr_i     - host preferred when both request
//   streak_max_i - the host holding the streak (~rr_ptr_i) has hit its cap
//   gnt_o        - one-hot grant (zero when no request)
//   winner_o     - index of the granted host (0 when no request)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  host_id_t   rr_ptr_i,
  input  logic       streak_max_i,
  output logic [1:0] gnt_o,
  output host_id_t   winner_o
);

  host_id_t streak_owner;

  always_comb begin
    // The streak always belongs to the most recent winner, which is the host
    // the pointer is not pointing at; a capped streak hands over to the other.
    streak_owner = ~rr_ptr_i;
    winner_o     = '0;
    gnt_o        = '0;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = streak_max_i ? ~streak_owner : rr_ptr_i;
      default: winner_o = '0;
    endcase
    if (|req_i) gnt_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: merges two req/gnt/rvalid hosts (0 = core LSU,
// 1 = debug/DMA) onto one port of the on-chip SRAM.
//   clk_i  - clock
//   rst_ni - synchronous active-low reset
//   bus    - ram_port_arbiter_if.slave: host buses and the RAM port
// Grants are zero-cycle, round-robin with a bounded streak (MaxStreak); the
// one-cycle RAM response is routed back to the host that issued it.
// Optional build macro RAM_ARB_RANGE_CHECK_EN: requests with word index
// >= Depth are granted but not forwarded, and answered next cycle with
// rvalid+err and zero data.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned Depth     = 16384,
  parameter int unsigned MaxStreak = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ram_port_arbiter_if.slave bus
);

  localparam streak_t StreakMax = streak_t'(MaxStreak);

  if (MaxStreak == 0 || MaxStreak > 15 || Depth == 0) begin : g_bad_cfg
    $error("ram_port_arbiter: MaxStreak must be 1..15 and Depth nonzero");
  end

  logic [NumHosts-1:0] req_act;
  logic [NumHosts-1:0] gnt;
  host_id_t            winner;
  host_id_t            rr_ptr_q;
  host_id_t            last_w_q;
  host_id_t            pend_id_q;
  streak_t             streak_q;
  logic                pend_vld_q;
  logic                pend_err;
  logic                any_gnt;
  logic                oob;
  logic                fwd;
  mem_req_t            win_req;
  logic                rsp_vld;
  logic                rsp_err;
  logic [31:0]         rsp_data;

  // No grants while in reset, so nothing reaches the RAM whose response
  // would arrive after the pending state has been cleared.
  assign req_act = rst_ni ? bus.h_req_i : '0;

  rr_arb2 u_rr_arb2 (
    .req_i        (req_act),
    .rr_ptr_i     (rr_ptr_q),
    .streak_max_i (streak_q == StreakMax),
    .gnt_o        (gnt),
    .winner_o     (winner)
  );

  assign any_gnt     = |gnt;
  assign bus.h_gnt_o = gnt;

  always_comb begin
    win_req = '0;
    if (any_gnt) begin
      win_req.we    = bus.h_we_i[winner];
      win_req.be    = bus.h_be_i[winner];
      win_req.addr  = bus.h_addr_i[winner];
      win_req.wdata = bus.h_wdata_i[winner];
    end
  end

`ifdef RAM_ARB_RANGE_CHECK_EN
  logic pend_err_q;

  assign oob = any_gnt && ({2'b00, win_req.addr[31:2]} >= 32'(Depth));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pend_err_q <= 1'b0;
    else         pend_err_q <= oob;
  end

  assign pend_err = pend_err_q;
`else
  assign oob      = 1'b0;
  assign pend_err = 1'b0;
`endif

  assign fwd             = any_gnt & ~oob;
  assign bus.ram_req_o   = fwd;
  assign bus.ram_we_o    = fwd & win_req.we;
  assign bus.ram_be_o    = fwd ? win_req.be    : '0;
  assign bus.ram_addr_o  = fwd ? win_req.addr  : '0;
  assign bus.ram_wdata_o = fwd ? win_req.wdata : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      last_w_q   <= '0;
      streak_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
    end else if (any_gnt) begin
      rr_ptr_q   <= ~winner;
      last_w_q   <= winner;
      streak_q   <= (winner == last_w_q) ? streak_bump(streak_q, StreakMax) : streak_t'(1);
      pend_vld_q <= 1'b1;
      pend_id_q  <= winner;
    end else begin
      pend_vld_q <= 1'b0;
    end
  end

  // Response path. A flagged range error completes locally instead of
  // waiting on the RAM; rvalid is held low while reset is asserted.
  assign rsp_vld  = rst_ni & pend_vld_q & (pend_err | bus.ram_rvalid_i);
  assign rsp_err  = rst_ni & pend_vld_q & pend_err;
  assign rsp_data = pend_err ? '0 : bus.ram_rdata_i;

  always_comb begin
    bus.h_rvalid_o            = '0;
    bus.h_err_o               = '0;
    bus.h_rvalid_o[pend_id_q] = rsp_vld;
    bus.h_err_o[pend_id_q]    = rsp_err;
  end

  assign bus.h_rdata_o = {rsp_data, rsp_data};

`ifndef SYNTHESIS
  a_no_orphan_rvalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.ram_rvalid_i |-> pend_vld_q);

  a_no_missing_rvalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (pend_vld_q && !pend_err) |-> bus.ram_rvalid_i);
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter.
// Directed table, hand-written corner sequences, and a randomized phase
// against a round-robin reference model. Range-check section is built only
// with RAM_ARB_RANGE_CHECK_EN.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned DEPTH      = 16384;
  localparam int unsigned MAX_STREAK = 2;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
  } host_in_t;

  typedef struct packed {
    host_in_t   in;
    logic [1:0] gnt;
    logic [1:0] rvalid;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ram_port_arbiter_if bus();

  ram_port_arbiter #(
    .Depth     (DEPTH),
    .MaxStreak (MAX_STREAK)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_0101);
  endfunction

  // One-cycle-latency RAM.
  always @(posedge clk) begin
    bus.ram_rvalid_i <= bus.ram_req_o;
    bus.ram_rdata_i  <= rdata_of(bus.ram_addr_o);
  end

  function automatic host_in_t mk_in(input logic [1:0] req, input logic [1:0] we,
                                     input logic [3:0] be1, input logic [31:0] a0,
                                     input logic [31:0] a1, input logic [31:0] w0,
                                     input logic [31:0] w1);
    host_in_t r;
    r.req = req; r.we = we; r.be0 = 4'hF; r.be1 = be1;
    r.a0 = a0; r.a1 = a1; r.w0 = w0; r.w1 = w1;
    return r;
  endfunction

  function automatic vec_t mk_vec(input host_in_t in, input logic [1:0] gnt,
                                  input logic [1:0] rvalid);
    vec_t v;
    v.in = in; v.gnt = gnt; v.rvalid = rvalid;
    return v;
  endfunction

  task automatic drive(input host_in_t in);
    bus.h_req_i      = in.req;
    bus.h_we_i       = in.we;
    bus.h_be_i[0]    = in.be0;
    bus.h_be_i[1]    = in.be1;
    bus.h_addr_i[0]  = in.a0;
    bus.h_addr_i[1]  = in.a1;
    bus.h_wdata_i[0] = in.w0;
    bus.h_wdata_i[1] = in.w1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input host_in_t in, input logic [1:0] g);
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] ea;
    logic [31:0] ew;
    ewe = 1'b0; ebe = '0; ea = '0; ew = '0;
    if (g[0]) begin
      ewe = in.we[0]; ebe = in.be0; ea = in.a0; ew = in.w0;
    end else if (g[1]) begin
      ewe = in.we[1]; ebe = in.be1; ea = in.a1; ew = in.w1;
    end
    chk({tag, "_ram_req"},   32'(bus.ram_req_o), 32'(|g));
    chk({tag, "_ram_we"},    32'(bus.ram_we_o),  32'(ewe));
    chk({tag, "_ram_be"},    32'(bus.ram_be_o),  32'(ebe));
    chk({tag, "_ram_addr"},  bus.ram_addr_o,     ea);
    chk({tag, "_ram_wdata"}, bus.ram_wdata_o,    ew);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive('0);
    @(negedge clk);
    #1;
    chk("rst_rvalid",  32'(bus.h_rvalid_o), 0);
    chk("rst_err",     32'(bus.h_err_o),    0);
    chk("rst_ram_req", 32'(bus.ram_req_o),  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t        tab [10];
  host_in_t    in;
  logic        prev_rd;
  logic [31:0] prev_data;
  // reference model state
  logic        m_last;
  logic        m_pend;
  logic        m_pid;
  logic        m_pread;
  logic [31:0] m_pdata;
  logic [1:0]  m_gnt;
  logic        m_w;
  logic        c_host;
  int unsigned c_run;

  initial begin
    drive('0);

    tab[0] = mk_vec(mk_in(2'b01, 2'b00, 4'hF,    32'h40,  32'h0,   32'h0, 32'h0),         2'b01, 2'b00);
    tab[1] = mk_vec(mk_in(2'b00, 2'b00, 4'hF,    32'h0,   32'h0,   32'h0, 32'h0),         2'b00, 2'b01);
    tab[2] = mk_vec(mk_in(2'b10, 2'b10, 4'b0101, 32'h0,   32'h8,   32'h0, 32'h11223344),  2'b10, 2'b00);
    tab[3] = mk_vec(mk_in(2'b11, 2'b00, 4'hF,    32'h100, 32'h200, 32'h0, 32'h0),         2'b01, 2'b10);
    tab[4] = mk_vec(mk_in(2'b11, 2'b00, 4'h3,    32'h104, 32'h204, 32'h0, 32'h0),         2'b10, 2'b01);
    tab[5] = mk_vec(mk_in(2'b11, 2'b01, 4'hF,    32'h108, 32'h208, 32'hCAFE0001, 32'h0),  2'b01, 2'b10);
    tab[6] = mk_vec(mk_in(2'b01, 2'b00, 4'hF,    32'h10C, 32'h0,   32'h0, 32'h0),         2'b01, 2'b01);
    tab[7] = mk_vec(mk_in(2'b11, 2'b00, 4'hC,    32'h110, 32'h20C, 32'h0, 32'h0),         2'b10, 2'b01);
    tab[8] = mk_vec(mk_in(2'b00, 2'b00, 4'hF,    32'h0,   32'h0,   32'h0, 32'h0),         2'b00, 2'b10);
    tab[9] = mk_vec(mk_in(2'b00, 2'b00, 4'hF,    32'h0,   32'h0,   32'h0, 32'h0),         2'b00, 2'b00);

    // ---- table-driven directed vectors ----
    do_reset();
    prev_rd = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tab[i].in);
      #1;
      chk($sformatf("tab%0d_gnt", i),    32'(bus.h_gnt_o),    32'(tab[i].gnt));
      chk_fwd($sformatf("tab%0d", i), tab[i].in, tab[i].gnt);
      chk($sformatf("tab%0d_rvalid", i), 32'(bus.h_rvalid_o), 32'(tab[i].rvalid));
      chk($sformatf("tab%0d_err", i),    32'(bus.h_err_o),    0);
      if (tab[i].rvalid != 2'b00 && prev_rd)
        chk($sformatf("tab%0d_rdata", i), bus.h_rdata_o[tab[i].rvalid[1]], prev_data);
      prev_rd   = 1'b0;
      prev_data = '0;
      if (tab[i].gnt[0]) begin
        prev_rd = ~tab[i].in.we[0]; prev_data = rdata_of(tab[i].in.a0);
      end else if (tab[i].gnt[1]) begin
        prev_rd = ~tab[i].in.we[1]; prev_data = rdata_of(tab[i].in.a1);
      end
    end

    // ---- h0 alone for 5 cycles, then h1 joins: h1 must win at once ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(mk_in(2'b01, 2'b00, 4'hF, 32'h300 + 32'(i * 4), 32'h0, 32'h0, 32'h0));
      #1;
      chk($sformatf("solo%0d_gnt", i), 32'(bus.h_gnt_o), 32'h1);
    end
    @(negedge clk);
    drive(mk_in(2'b11, 2'b00, 4'hF, 32'h400, 32'h500, 32'h0, 32'h0));
    #1;
    chk("join_gnt",    32'(bus.h_gnt_o),    32'h2);
    chk("join_rvalid", 32'(bus.h_rvalid_o), 32'h1);
    @(negedge clk);
    #1;
    chk("join2_gnt",   32'(bus.h_gnt_o),    32'h1);
    chk("join2_rvalid", 32'(bus.h_rvalid_o), 32'h2);

    // ---- reset in the cycle after a grant ----
    @(negedge clk);
    drive(mk_in(2'b11, 2'b00, 4'hF, 32'h600, 32'h700, 32'h0, 32'h0));
    #1;
    chk("rstmid_n_gnt", 32'(bus.h_gnt_o), 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_n1_rvalid",  32'(bus.h_rvalid_o), 0);
    chk("rstmid_n1_gnt",     32'(bus.h_gnt_o),    0);
    chk("rstmid_n1_ram_req", 32'(bus.ram_req_o),  0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('0);
    #1;
    chk("rstmid_n2_rvalid", 32'(bus.h_rvalid_o), 0);
    @(negedge clk);
    drive(mk_in(2'b11, 2'b00, 4'hF, 32'h800, 32'h900, 32'h0, 32'h0));
    #1;
    chk("rstmid_ptr_gnt", 32'(bus.h_gnt_o), 32'h1);

`ifdef RAM_ARB_RANGE_CHECK_EN
    // ---- out-of-range request answered locally with error ----
    do_reset();
    @(negedge clk);
    drive(mk_in(2'b01, 2'b00, 4'hF, 32'h0001_0000, 32'h0, 32'h0, 32'h0));
    #1;
    chk("oob_gnt",     32'(bus.h_gnt_o),   32'h1);
    chk("oob_ram_req", 32'(bus.ram_req_o), 0);
    @(negedge clk);
    drive(mk_in(2'b01, 2'b00, 4'hF, 32'h0000_FFFC, 32'h0, 32'h0, 32'h0));
    #1;
    chk("oob_rvalid",  32'(bus.h_rvalid_o), 32'h1);
    chk("oob_err",     32'(bus.h_err_o),    32'h1);
    chk("oob_rdata",   bus.h_rdata_o[0],    32'h0);
    chk("edge_ram_req", 32'(bus.ram_req_o), 32'h1);
    chk("edge_addr",   bus.ram_addr_o,      32'h0000_FFFC);
    @(negedge clk);
    drive('0);
    #1;
    chk("edge_rvalid", 32'(bus.h_rvalid_o), 32'h1);
    chk("edge_err",    32'(bus.h_err_o),    0);
    chk("edge_rdata",  bus.h_rdata_o[0],    rdata_of(32'h0000_FFFC));
`endif

    // ---- randomized traffic against the round-robin reference model ----
    do_reset();
    m_last = 1'b1;   // host 0 is preferred first after reset
    m_pend = 1'b0;
    m_pid = 1'b0;
    m_pread = 1'b0;
    m_pdata = '0;
    c_host = 1'b0;
    c_run = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in.req = 2'($urandom_range(0, 3));
      in.we  = 2'($urandom);
      in.be0 = 4'($urandom);
      in.be1 = 4'($urandom);
      in.a0  = $urandom & 32'h0000_FFFC;
      in.a1  = $urandom & 32'h0000_FFFC;
      in.w0  = $urandom;
      in.w1  = $urandom;
      drive(in);
      // Round robin: a sole requester wins; with both, the host that was
      // not granted most recently wins.
      m_w = (in.req == 2'b11) ? ~m_last : in.req[1];
      m_gnt = (in.req == 2'b00) ? 2'b00 : (m_w ? 2'b10 : 2'b01);
      #1;
      chk("rnd_gnt", 32'(bus.h_gnt_o), 32'(m_gnt));
      chk_fwd("rnd", in, m_gnt);
      chk("rnd_rvalid", 32'(bus.h_rvalid_o), m_pend ? (m_pid ? 32'h2 : 32'h1) : 32'h0);
      chk("rnd_err", 32'(bus.h_err_o), 0);
      if (m_pend && m_pread) chk("rnd_rdata", bus.h_rdata_o[m_pid], m_pdata);
      if (in.req == 2'b11) begin
        if (c_run != 0 && bus.h_gnt_o[c_host]) c_run++;
        else begin
          c_run  = 1;
          c_host = bus.h_gnt_o[1];
        end
        chk("rnd_fair", 32'(c_run <= MAX_STREAK), 32'h1);
      end else begin
        c_run = 0;
      end
      if (in.req != 2'b00) begin
        m_last  = m_w;
        m_pend  = 1'b1;
        m_pid   = m_w;
        m_pread = ~in.we[m_w];
        m_pdata = rdata_of(m_w ? in.a1 : in.a0);
      end else begin
        m_pend = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
